// File: rtl/updown_counter_n_if.sv
// Bus bundle for updown_counter_n: control/data inputs and count/status outputs.
// The clock and reset stay outside this interface as plain ports.
interface updown_counter_n_if #(
    parameter int unsigned WIDTH = 8
);
    logic             iEnable;
    logic             iClear;
    logic             iLoad;
    logic [WIDTH-1:0] iLoadValue;
    logic             iUp_down;
    logic [WIDTH-1:0] iLimit;
    logic [1:0]       iMode;
    logic [WIDTH-1:0] oData;
    logic             oTc;
    logic             oDone;
    logic             oAtMax;
    logic             oAtMin;

    modport master (
        output iEnable, iClear, iLoad, iLoadValue, iUp_down, iLimit, iMode,
        input  oData, oTc, oDone, oAtMax, oAtMin
    );

    modport slave (
        input  iEnable, iClear, iLoad, iLoadValue, iUp_down, iLimit, iMode,
        output oData, oTc, oDone, oAtMax, oAtMin
    );
endinterface

// File: rtl/updown_counter_n.sv
// Bounded up/down counter over 0..iLimit with wrap, saturate and one-shot boundary modes.
// A two-state RUN/DONE FSM freezes the count after a one-shot terminal event.
module updown_counter_n #(
    parameter int unsigned WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'd0
) (
    input logic               iClk,
    input logic               iReset,
    updown_counter_n_if.slave bus
);
    typedef enum logic {StRun, StDone} state_e;

    localparam logic [WIDTH-1:0] ResetData = RESET_VALUE[WIDTH-1:0];

    state_e           r_state;
    state_e           w_state_d;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_d;
    logic             r_tc;
    logic             w_tc_d;
    logic             w_run;
    logic             w_up_term;
    logic             w_dn_term;
    logic             w_wrap;
    logic             w_oneshot;

    assign w_run     = (r_state == StRun);
    // >= rather than == so a lowered iLimit still makes an up step terminal
    assign w_up_term = bus.iEnable & bus.iUp_down & w_run & (r_data >= bus.iLimit);
    assign w_dn_term = bus.iEnable & ~bus.iUp_down & w_run & (r_data == '0);
    assign w_wrap    = (bus.iMode[0] == bus.iMode[1]);
    assign w_oneshot = (bus.iMode == 2'b10);

    // State register
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        if (bus.iClear || bus.iLoad) begin
            w_state_d = StRun;
        end else if ((w_up_term || w_dn_term) && w_oneshot) begin
            w_state_d = StDone;
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_data <= ResetData;
            r_tc   <= 1'b0;
        end else begin
            r_data <= w_data_d;
            r_tc   <= w_tc_d;
        end
    end

    always_comb begin
        w_data_d = r_data;
        w_tc_d   = 1'b0;
        if (bus.iClear) begin
            w_data_d = '0;
        end else if (bus.iLoad) begin
            w_data_d = (bus.iLoadValue > bus.iLimit) ? bus.iLimit : bus.iLoadValue;
        end else if (w_up_term) begin
            w_tc_d   = 1'b1;
            w_data_d = w_wrap ? '0 : bus.iLimit;
        end else if (w_dn_term) begin
            w_tc_d   = 1'b1;
            w_data_d = w_wrap ? bus.iLimit : '0;
        end else if (bus.iEnable && w_run) begin
            w_data_d = bus.iUp_down ? r_data + WIDTH'(1) : r_data - WIDTH'(1);
        end
    end

    // Output logic
    always_comb begin
        bus.oData  = r_data;
        bus.oTc    = r_tc;
        bus.oDone  = (r_state == StDone);
        bus.oAtMax = (r_data >= bus.iLimit);
        bus.oAtMin = (r_data == '0);
    end
endmodule

// File: tb/tb_updown_counter_n.sv
// Self-checking bench for updown_counter_n: directed boundary scenarios plus
// randomized traffic checked against a cycle-level behavioural model.
module tb_updown_counter_n;
    localparam int unsigned WIDTH = 8;
    localparam int          RV    = 5;

    logic iClk = 1'b0;
    logic iReset;
    always #5 iClk = ~iClk;

    updown_counter_n_if #(.WIDTH(WIDTH)) bus ();

    updown_counter_n #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(32'(RV))
    ) dut (
        .iClk  (iClk),
        .iReset(iReset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int m_data;
    bit m_done;
    bit m_tc;

    // Reference: one clock edge of the counter, from the current inputs.
    function automatic void model_step();
        int lim;
        int lv;
        bit sat;
        lim = int'(bus.iLimit);
        lv  = int'(bus.iLoadValue);
        sat = (bus.iMode == 2'd1) || (bus.iMode == 2'd2);
        m_tc = 1'b0;
        if (bus.iClear) begin
            m_data = 0;
            m_done = 1'b0;
        end else if (bus.iLoad) begin
            m_data = (lv < lim) ? lv : lim;
            m_done = 1'b0;
        end else if (bus.iEnable && !m_done) begin
            if (bus.iUp_down && m_data >= lim) begin
                m_tc   = 1'b1;
                m_data = sat ? lim : 0;
                m_done = (bus.iMode == 2'd2);
            end else if (!bus.iUp_down && m_data == 0) begin
                m_tc   = 1'b1;
                m_data = sat ? 0 : lim;
                m_done = (bus.iMode == 2'd2);
            end else begin
                m_data = bus.iUp_down ? m_data + 1 : m_data - 1;
            end
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge iClk);
        #1;
    endtask

    task automatic set_idle();
        bus.iEnable    = 1'b0;
        bus.iClear     = 1'b0;
        bus.iLoad      = 1'b0;
        bus.iLoadValue = '0;
        bus.iUp_down   = 1'b1;
        bus.iLimit     = 8'd9;
        bus.iMode      = 2'd0;
    endtask

    task automatic do_load(input int v);
        bus.iEnable    = 1'b0;
        bus.iLoad      = 1'b1;
        bus.iLoadValue = WIDTH'(v);
        tick();
        bus.iLoad = 1'b0;
    endtask

    task automatic test_reset();
        iReset = 1'b1;
        set_idle();
        #12;
        n_cmp++;
        if (bus.oData !== WIDTH'(RV)) begin
            n_bad++; $display("FAIL reset_data: got %0d want %0d", bus.oData, RV);
        end
        n_cmp++;
        if (bus.oTc !== 1'b0 || bus.oDone !== 1'b0 || bus.oAtMin !== 1'b0) begin
            n_bad++; $display("FAIL reset_flags: got tc=%b done=%b atmin=%b want 0 0 0",
                              bus.oTc, bus.oDone, bus.oAtMin);
        end
        @(negedge iClk);
        iReset = 1'b0;
        m_data = RV; m_done = 1'b0; m_tc = 1'b0;
    endtask

    task automatic test_wrap_up();
        int exp[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        bus.iLimit = 8'd9; bus.iMode = 2'd0; bus.iUp_down = 1'b1;
        do_load(0);
        bus.iEnable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_cmp++;
            if (bus.oData !== WIDTH'(exp[i])) begin
                n_bad++; $display("FAIL wrap_data[%0d]: got %0d want %0d", i, bus.oData, exp[i]);
            end
            n_cmp++;
            if (bus.oTc !== (exp[i] == 0)) begin
                n_bad++; $display("FAIL wrap_tc[%0d]: got %b want %b", i, bus.oTc, exp[i] == 0);
            end
        end
        bus.iEnable = 1'b0;
    endtask

    task automatic test_sat_down();
        int exp_d[4] = '{1, 0, 0, 0};
        bit exp_t[4] = '{0, 0, 1, 1};
        bus.iLimit = 8'd9; bus.iMode = 2'd1; bus.iUp_down = 1'b0;
        do_load(2);
        bus.iEnable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (bus.oData !== WIDTH'(exp_d[i]) || bus.oTc !== exp_t[i]) begin
                n_bad++; $display("FAIL sat_down[%0d]: got data=%0d tc=%b want data=%0d tc=%b",
                                  i, bus.oData, bus.oTc, exp_d[i], exp_t[i]);
            end
        end
        bus.iEnable = 1'b0;
    endtask

    task automatic test_oneshot();
        int exp_d[6] = '{4, 5, 5, 5, 5, 5};
        bit exp_t[6] = '{0, 0, 1, 0, 0, 0};
        bit exp_n[6] = '{0, 0, 1, 1, 1, 1};
        bus.iLimit = 8'd5; bus.iMode = 2'd2; bus.iUp_down = 1'b1;
        do_load(3);
        bus.iEnable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) bus.iMode = 2'd0;  // mode change must not leave DONE
            tick();
            n_cmp++;
            if (bus.oData !== WIDTH'(exp_d[i]) || bus.oTc !== exp_t[i] ||
                bus.oDone !== exp_n[i]) begin
                n_bad++;
                $display("FAIL oneshot[%0d]: got data=%0d tc=%b done=%b want %0d %b %b",
                         i, bus.oData, bus.oTc, bus.oDone, exp_d[i], exp_t[i], exp_n[i]);
            end
        end
        do_load(2);
        n_cmp++;
        if (bus.oData !== 8'd2 || bus.oDone !== 1'b0) begin
            n_bad++; $display("FAIL oneshot_exit: got data=%0d done=%b want 2 0",
                              bus.oData, bus.oDone);
        end
    endtask

    task automatic test_clear_load();
        bus.iLimit = 8'd9; bus.iMode = 2'd0;
        do_load(4);
        bus.iClear = 1'b1; bus.iLoad = 1'b1; bus.iLoadValue = 8'd7; bus.iEnable = 1'b1;
        tick();
        bus.iClear = 1'b0; bus.iLoad = 1'b0; bus.iEnable = 1'b0;
        n_cmp++;
        if (bus.oData !== 8'd0 || bus.oTc !== 1'b0) begin
            n_bad++; $display("FAIL clear_prio: got data=%0d tc=%b want 0 0", bus.oData, bus.oTc);
        end
        bus.iLimit = 8'd50;
        do_load(200);
        n_cmp++;
        if (bus.oData !== 8'd50 || bus.oAtMax !== 1'b1) begin
            n_bad++; $display("FAIL load_clamp: got data=%0d atmax=%b want 50 1",
                              bus.oData, bus.oAtMax);
        end
    endtask

    task automatic test_limit_drop();
        for (int m = 0; m < 3; m++) begin
            bus.iMode = (m == 1) ? 2'd1 : 2'd0;
            bus.iUp_down = (m != 2);
            bus.iLimit = 8'd50;
            do_load(40);
            bus.iLimit = 8'd30;
            #1;
            n_cmp++;
            if (bus.oAtMax !== 1'b1) begin
                n_bad++; $display("FAIL drop_atmax[%0d]: got %b want 1", m, bus.oAtMax);
            end
            bus.iEnable = 1'b1;
            tick();
            bus.iEnable = 1'b0;
            n_cmp++;
            if (m == 0 && (bus.oData !== 8'd0 || bus.oTc !== 1'b1)) begin
                n_bad++; $display("FAIL drop_wrap: got data=%0d tc=%b want 0 1", bus.oData, bus.oTc);
            end else if (m == 1 && (bus.oData !== 8'd30 || bus.oTc !== 1'b1)) begin
                n_bad++; $display("FAIL drop_sat: got data=%0d tc=%b want 30 1", bus.oData, bus.oTc);
            end else if (m == 2 && (bus.oData !== 8'd39 || bus.oTc !== 1'b0)) begin
                n_bad++; $display("FAIL drop_down: got data=%0d tc=%b want 39 0", bus.oData, bus.oTc);
            end
        end
    endtask

    task automatic test_async_reset();
        bus.iLimit = 8'd100; bus.iMode = 2'd0; bus.iUp_down = 1'b1;
        do_load(10);
        bus.iEnable = 1'b1;
        tick(); tick();
        for (int p = 0; p < 2; p++) begin
            #2 iReset = 1'b1;
            #1;
            n_cmp++;
            if (bus.oData !== WIDTH'(RV) || bus.oTc !== 1'b0 || bus.oDone !== 1'b0) begin
                n_bad++; $display("FAIL async_reset[%0d]: got data=%0d tc=%b done=%b want %0d 0 0",
                                  p, bus.oData, bus.oTc, bus.oDone, RV);
            end
            #1 iReset = 1'b0;
            m_data = RV; m_done = 1'b0; m_tc = 1'b0;
            if (p == 0) begin
                tick();
                n_cmp++;
                if (bus.oData !== WIDTH'(RV + 1)) begin
                    n_bad++; $display("FAIL resume: got %0d want %0d", bus.oData, RV + 1);
                end
                bus.iMode = 2'd2; bus.iLimit = 8'd7;
                do_load(6);
                bus.iEnable = 1'b1;
                tick(); tick();
                n_cmp++;
                if (bus.oDone !== 1'b1 || bus.oTc !== 1'b1) begin
                    n_bad++; $display("FAIL reach_done: got done=%b tc=%b want 1 1",
                                      bus.oDone, bus.oTc);
                end
            end
        end
        bus.iEnable = 1'b0;
    endtask

    task automatic test_random();
        bus.iLimit = 8'd12;
        for (int i = 0; i < 400; i++) begin
            bus.iClear     = ($urandom_range(0, 29) == 0);
            bus.iLoad      = ($urandom_range(0, 9) == 0);
            bus.iEnable    = ($urandom_range(0, 3) != 0);
            bus.iUp_down   = 1'($urandom_range(0, 1));
            bus.iMode      = 2'($urandom_range(0, 3));
            bus.iLoadValue = WIDTH'($urandom_range(0, 25));
            if ($urandom_range(0, 19) == 0) bus.iLimit = WIDTH'($urandom_range(0, 20));
            tick();
            n_cmp++;
            if (bus.oData !== WIDTH'(m_data) || bus.oTc !== m_tc || bus.oDone !== m_done ||
                bus.oAtMax !== (m_data >= int'(bus.iLimit)) || bus.oAtMin !== (m_data == 0)) begin
                n_bad++;
                $display("FAIL random[%0d]: got data=%0d tc=%b done=%b max=%b min=%b want %0d %b %b %b %b",
                         i, bus.oData, bus.oTc, bus.oDone, bus.oAtMax, bus.oAtMin, m_data, m_tc,
                         m_done, m_data >= int'(bus.iLimit), m_data == 0);
            end
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_oneshot();
        test_clear_load();
        test_limit_drop();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/updown_counter_n.md
UPDOWN_COUNTER_N -- requirements
Module: updown_counter_n

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 Parameter RESET_VALUE, default 0: oData value after reset, truncated to WIDTH bits.
REQ-003 iClk  input  1: single clock, all state updates on its rising edge.
REQ-004 iReset  input  1: reset, asynchronous and active-high.
REQ-005 iEnable  input  1: count enable, one step per cycle while high.
REQ-006 iClear  input  1: synchronous clear of oData to 0.
REQ-007 iLoad  input  1: synchronous load of iLoadValue.
REQ-008 iLoadValue  input  WIDTH: value captured by iLoad.
REQ-009 iUp_down  input  1: direction, 1 = up, 0 = down.
REQ-010 iLimit  input  WIDTH: upper bound; count range is 0..iLimit inclusive.
REQ-011 iMode  input  2: boundary mode, 00 = wrap, 01 = saturate, 10 = one-shot, 11 = wrap.
REQ-012 oData  output  WIDTH: registered count value.
REQ-013 oTc  output  1: registered terminal-count pulse.
REQ-014 oDone  output  1: registered, high while the one-shot FSM is in DONE.
REQ-015 oAtMax  output  1: combinational, high when oData >= iLimit.
REQ-016 oAtMin  output  1: combinational, high when oData == 0.

Function
REQ-017 Priority, highest first, SHALL be: iReset, iClear, iLoad, iEnable count, hold.
REQ-018 iClear SHALL set oData to 0, state to RUN and oTc to 0, regardless of iEnable and iLoad.
REQ-019 iLoad SHALL set oData to min(iLoadValue, iLimit), state to RUN and oTc to 0.
REQ-020 With iEnable high, iUp_down high, state RUN and oData < iLimit, oData SHALL increment by 1 on the next edge.
REQ-021 With iEnable high, iUp_down low, state RUN and oData > 0, oData SHALL decrement by 1 on the next edge.
REQ-022 An up terminal event is defined as iEnable high, iUp_down high, state RUN and oData >= iLimit.
REQ-023 A down terminal event is defined as iEnable high, iUp_down low, state RUN and oData == 0.
REQ-024 On a terminal event in wrap mode, oData SHALL take 0 for an up event or iLimit for a down event.
REQ-025 On a terminal event in saturate mode, oData SHALL take iLimit for an up event or hold 0 for a down event.
REQ-026 On a terminal event in one-shot mode, oData SHALL take the same values as saturate and state SHALL go RUN -> DONE.
REQ-027 oTc SHALL be 1 for exactly the cycle following each terminal event edge, and 0 otherwise.
REQ-028 In saturate mode, oTc SHALL reassert on every enabled cycle held at the bound.
REQ-029 The FSM SHALL have two states: RUN (counting permitted) and DONE (count frozen).
REQ-030 In DONE, iEnable SHALL be ignored, oData SHALL hold, and oTc SHALL stay 0.
REQ-031 Only iClear, iLoad or iReset SHALL exit DONE.
REQ-032 A change of iMode while in DONE SHALL NOT exit DONE.
REQ-033 If iLimit drops below oData, an up event SHALL be treated as terminal per REQ-022, and down counting SHALL proceed normally.
REQ-034 iLimit == 0 SHALL be legal: every enabled step is terminal and oData stays 0.
REQ-035 All arithmetic SHALL be WIDTH bits, with no internal overflow beyond the explicit bound handling.

Reset
REQ-036 While iReset is high, asynchronously: oData = RESET_VALUE, state = RUN, oTc = 0, oDone = 0.
REQ-037 Reset asserted mid-count or in DONE SHALL take effect immediately without waiting for iClk.
REQ-038 Counting SHALL resume on the first iClk edge after iReset deasserts.

Verification
REQ-039 The bench SHALL cover these directed scenarios:
- WIDTH=8, iLimit=9, wrap, up, iEnable held 12 cycles from 0 -> oData 1..9, 0, 1, 2; oTc high the one cycle oData shows 0.
- iLimit=9, saturate, down from 2, 4 enables -> oData 1, 0, 0, 0; oTc high on the last two cycles.
- iLimit=5, one-shot, up from 3 -> oData 4, 5, 5; oDone=1 after the 3rd enable; further enables leave oData 5, oTc 0; iLoad=2 -> oData 2, oDone 0.
- iClear, iLoad=7 and iEnable in the same cycle -> oData 0; iLoad=200 with iLimit=50 -> oData 50.
- oData=40, iLimit lowered to 30, one up enable -> wrap mode oData 0 with oTc 1; saturate mode oData 30.
- iReset pulsed between clock edges during counting and again in DONE -> oData = RESET_VALUE immediately, oDone 0, oTc 0.
